// File: rtl/hbridge_step_sequencer_if.sv
// hbridge_step_sequencer_if: config bus, run control and drive outputs of the step sequencer
interface hbridge_step_sequencer_if #(
   parameter int NUM_OF_DRIVERS = 8,
   parameter int DEPTH = 16
);
   localparam int IW = $clog2(DEPTH);
   localparam int AW = IW + 1;
   logic cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [31:0] cfg_wdata;
   logic control_trigger;
   logic latch_data;
   logic stop;
   logic [2*NUM_OF_DRIVERS-1:0] driver_io;
   logic busy;
   logic update_cycle_complete;
   logic [IW-1:0] step_index;
   modport master (
      output cfg_we, cfg_addr, cfg_wdata, control_trigger, latch_data, stop,
      input driver_io, busy, update_cycle_complete, step_index
   );
   modport slave (
      input cfg_we, cfg_addr, cfg_wdata, control_trigger, latch_data, stop,
      output driver_io, busy, update_cycle_complete, step_index
   );
endinterface

// File: rtl/hbridge_step_sequencer.sv
// hbridge_step_sequencer: plays a pattern of H-bridge drive codes with per-channel reversal dead time
module hbridge_step_sequencer #(
   parameter int NUM_OF_DRIVERS = 8,
   parameter int DEPTH = 16,
   parameter int PRESCALE_W = 16,
   parameter int DEAD_W = 4
) (
   input logic clock,
   input logic reset,
   hbridge_step_sequencer_if.slave bus
);
   localparam int W = 2 * NUM_OF_DRIVERS;
   localparam int IW = $clog2(DEPTH);
   localparam int AW = IW + 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic trig_q, latch_q, trig_edge, latch_edge;
   logic [PRESCALE_W-1:0] sh_period, ac_period, np, timer;
   logic [IW-1:0] sh_last, ac_last, idx, nidx;
   logic sh_loop, ac_loop, pend;
   logic [DEAD_W-1:0] sh_dead, ac_dead, nd, eff, dl;
   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] tgt, mask, drv, nw, nmask;
   logic busy_q, ucc_q, expire, at_last, start, boundary, apply, load;
   logic [32:0] p1;
   logic [31:0] sel;
   logic unused;
   assign unused = ^{bus.cfg_wdata, bus.cfg_addr};
   assign sel = 32'(bus.cfg_addr[AW-2:0]);
   always_comb begin
      trig_edge = bus.control_trigger & ~trig_q;
      latch_edge = bus.latch_data & ~latch_q;
      expire = timer == ac_period;
      at_last = idx == ac_last;
      start = state == IDLE && trig_edge && !bus.stop;
      boundary = state == RUN && !bus.stop && expire && at_last;
      // a latch arriving on the boundary cycle itself is applied at that boundary
      apply = (state == IDLE && latch_edge) || (boundary && (pend || latch_edge));
      load = start || (state == RUN && !bus.stop && expire && (!at_last || ac_loop));
      nidx = (start || at_last) ? '0 : idx + IW'(1);
      np = apply ? sh_period : ac_period;
      nd = apply ? sh_dead : ac_dead;
      p1 = 33'(np) + 33'd1;
      eff = (p1 < 33'(nd)) ? DEAD_W'(p1) : nd;
      nw = mem[nidx];
      state_n = (start || (state == RUN && !bus.stop && !(boundary && !ac_loop))) ? RUN : IDLE;
      nmask = '0;
      // dead time only on a direct forward<->reverse swap
      for (int c = 0; c < NUM_OF_DRIVERS; c++)
         nmask[2*c +: 2] = {2{((tgt[2*c +: 2] ^ nw[2*c +: 2]) == 2'b11) && ^tgt[2*c +: 2]}};
   end
   always_ff @(posedge clock)
      if (bus.cfg_we && !bus.cfg_addr[AW-1]) mem[bus.cfg_addr[IW-1:0]] <= bus.cfg_wdata[W-1:0];
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         {trig_q, latch_q, pend, busy_q, ucc_q} <= '0;
         {sh_period, ac_period, timer} <= '0;
         {sh_last, ac_last, idx} <= '0;
         {sh_loop, ac_loop} <= '0;
         {sh_dead, ac_dead, dl} <= '0;
         {tgt, mask, drv} <= '0;
      end else begin
         state <= state_n;
         trig_q <= bus.control_trigger;
         latch_q <= bus.latch_data;
         if (bus.cfg_we && bus.cfg_addr[AW-1]) begin
            if (sel == 32'd0) sh_period <= bus.cfg_wdata[PRESCALE_W-1:0];
            if (sel == 32'd1) sh_last <= bus.cfg_wdata[IW-1:0];
            if (sel == 32'd2) sh_loop <= bus.cfg_wdata[0];
            if (sel == 32'd3) sh_dead <= bus.cfg_wdata[DEAD_W-1:0];
         end
         if (apply) begin
            ac_period <= sh_period;
            ac_last <= sh_last;
            ac_loop <= sh_loop;
            ac_dead <= sh_dead;
         end
         pend <= (bus.stop || apply) ? 1'b0 : (state == RUN && latch_edge) ? 1'b1 : pend;
         busy_q <= state_n == RUN;
         ucc_q <= boundary;
         if (state_n == IDLE) begin
            {idx, timer, dl, tgt, mask, drv} <= '0;
         end else if (load) begin
            idx <= nidx;
            timer <= '0;
            tgt <= nw;
            mask <= nmask;
            dl <= (eff == '0) ? '0 : eff - DEAD_W'(1);
            drv <= (eff == '0) ? nw : nw & ~nmask;
         end else begin
            timer <= timer + PRESCALE_W'(1);
            dl <= (dl != '0) ? dl - DEAD_W'(1) : dl;
            drv <= (dl != '0) ? tgt & ~mask : tgt;
         end
      end
   end
   assign bus.driver_io = drv;
   assign bus.busy = busy_q;
   assign bus.update_cycle_complete = ucc_q;
   assign bus.step_index = idx;
endmodule

// File: tb/tb_hbridge_step_sequencer.sv
// tb_hbridge_step_sequencer: directed vectors for playback, looping, dead time, latching and abort
module tb_hbridge_step_sequencer;
   localparam int N = 8;
   localparam int DEPTH = 16;
   localparam logic [4:0] REG = 5'b10000;
   logic clock = 1'b0;
   logic reset;
   int tests = 0;
   int fails = 0;
   hbridge_step_sequencer_if #(.NUM_OF_DRIVERS(N), .DEPTH(DEPTH)) bus();
   hbridge_step_sequencer #(.NUM_OF_DRIVERS(N), .DEPTH(DEPTH), .PRESCALE_W(16), .DEAD_W(4)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );
   always #5 clock = ~clock;
   typedef struct {
      logic trig;
      logic stop;
      logic [15:0] drv;
      logic busy;
      logic ucc;
      logic [3:0] idx;
   } vec_t;
   vec_t tbl [14];
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask
   task automatic chk_out(input string nm, input logic [15:0] drv, input logic busy, input logic ucc, input logic [3:0] idx);
      chk({nm, " driver_io"}, 32'(bus.driver_io), 32'(drv));
      chk({nm, " busy"}, 32'(bus.busy), 32'(busy));
      chk({nm, " ucc"}, 32'(bus.update_cycle_complete), 32'(ucc));
      chk({nm, " step_index"}, 32'(bus.step_index), 32'(idx));
   endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we = 1'b0;
   endtask
   task automatic setup(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input int per, input int last, input int mode, input int dead);
      wr(5'd0, 32'(a));
      wr(5'd1, 32'(b));
      wr(5'd2, 32'(c));
      wr(REG | 5'd0, 32'(per));
      wr(REG | 5'd1, 32'(last));
      wr(REG | 5'd2, 32'(mode));
      wr(REG | 5'd3, 32'(dead));
      bus.latch_data = 1'b1;
      tick();
      bus.latch_data = 1'b0;
      tick();
   endtask
   initial begin
      // one-shot P=3, last=2; trigger re-rises at row 5 while running and must be ignored
      tbl = '{
         '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 4'd0},
         '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 4'd0},
         '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 4'd0},
         '{1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 4'd0},
         '{1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 4'd1},
         '{1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 4'd1},
         '{1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 4'd1},
         '{1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 4'd1},
         '{1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 4'd2},
         '{1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 4'd2},
         '{1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 4'd2},
         '{1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 4'd2},
         '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0},
         '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0}
      };
      reset = 1'b1;
      bus.cfg_we = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_wdata = '0;
      bus.control_trigger = 1'b0;
      bus.latch_data = 1'b0;
      bus.stop = 1'b0;
      tick();
      tick();
      chk_out("reset", 16'h0, 1'b0, 1'b0, 4'd0);
      reset = 1'b0;
      setup(16'h0001, 16'h0004, 16'h0010, 3, 2, 0, 0);
      for (int i = 0; i < 14; i++) begin
         bus.control_trigger = tbl[i].trig;
         bus.stop = tbl[i].stop;
         tick();
         chk_out($sformatf("oneshot[%0d]", i), tbl[i].drv, tbl[i].busy, tbl[i].ucc, tbl[i].idx);
      end
      bus.control_trigger = 1'b1;
      bus.stop = 1'b1;
      tick();
      chk_out("trig_stop_idle", 16'h0, 1'b0, 1'b0, 4'd0);
      bus.control_trigger = 1'b0;
      bus.stop = 1'b0;
      tick();
      chk_out("trig_stop_idle2", 16'h0, 1'b0, 1'b0, 4'd0);
      // loop P=0 alternating fwd/rev, trigger toggled mid-run, then stop on a boundary cycle
      setup(16'h0001, 16'h0002, 16'h0000, 0, 1, 1, 0);
      for (int i = 0; i < 8; i++) begin
         bus.control_trigger = (i != 4);
         tick();
         chk_out($sformatf("loop[%0d]", i), (i % 2) ? 16'h2 : 16'h1, 1'b1,
                 i >= 2 && i % 2 == 0, 4'(i % 2));
      end
      bus.stop = 1'b1;
      tick();
      chk_out("loop_stop", 16'h0, 1'b0, 1'b0, 4'd0);
      bus.stop = 1'b0;
      bus.control_trigger = 1'b0;
      tick();
      // dead=2, P=4: ch0 reverses (gap), ch1 goes to brake at once
      setup(16'h0005, 16'h000E, 16'h0000, 4, 1, 0, 2);
      for (int i = 0; i < 11; i++) begin
         bus.control_trigger = (i == 0);
         tick();
         chk_out($sformatf("dead2[%0d]", i),
                 i < 5 ? 16'h5 : i < 7 ? 16'hC : i < 10 ? 16'hE : 16'h0,
                 i < 10, i == 10, i < 5 ? 4'd0 : i < 10 ? 4'd1 : 4'd0);
      end
      // dead=7 clipped to the whole 3-cycle step
      setup(16'h0001, 16'h0002, 16'h0003, 2, 2, 0, 7);
      for (int i = 0; i < 10; i++) begin
         bus.control_trigger = (i == 0);
         tick();
         chk_out($sformatf("dead7[%0d]", i),
                 i < 3 ? 16'h1 : i < 6 ? 16'h0 : i < 9 ? 16'h3 : 16'h0,
                 i < 9, i == 9, i < 3 ? 4'd0 : i < 6 ? 4'd1 : i < 9 ? 4'd2 : 4'd0);
      end
      // latch mid-pass: P=1 holds for this pass, P=9 from the boundary on
      setup(16'h0001, 16'h0002, 16'h0000, 1, 1, 1, 0);
      for (int i = 0; i < 15; i++) begin
         bus.control_trigger = 1'b1;
         bus.cfg_we = (i == 1);
         bus.cfg_addr = REG | 5'd0;
         bus.cfg_wdata = 32'd9;
         bus.latch_data = (i == 2);
         tick();
         chk_out($sformatf("latch[%0d]", i), (i == 2 || i == 3 || i == 14) ? 16'h2 : 16'h1, 1'b1,
                 i == 4, (i == 2 || i == 3 || i == 14) ? 4'd1 : 4'd0);
      end
      bus.cfg_we = 1'b0;
      bus.latch_data = 1'b0;
      bus.control_trigger = 1'b0;
      reset = 1'b1;
      tick();
      chk_out("reset_mid", 16'h0, 1'b0, 1'b0, 4'd0);
      reset = 1'b0;
      tick();
      chk_out("post_reset_idle", 16'h0, 1'b0, 1'b0, 4'd0);
      // defaults P=0, last=0, one-shot; pattern memory survives reset
      bus.control_trigger = 1'b1;
      tick();
      chk_out("default_run", 16'h1, 1'b1, 1'b0, 4'd0);
      bus.control_trigger = 1'b0;
      tick();
      chk_out("default_end", 16'h0, 1'b0, 1'b1, 4'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
